axi_rdata_merge4k: RTL and testbench
====================================

# axi_rdata_merge4k

Read-response merger on the AXI R channel of the iDMA read path. The address-side 4 KB splitter may issue one DMA burst as two AXI bursts. This block recombines their R beats into a single DMA burst with exactly one `last`, a merged response code, and a one-cycle burst-complete pulse. It sits between the AXI master R port and the DMA read-data consumer, fed by per-burst descriptors captured at address-handshake time.

## Interface
Parameters:
- `AXI_IDW`, 4, R-channel ID width; ID is ignored.
- `DATA_W`, 256, R data width; must match AxSIZE = 5.
- `DESC_DEPTH`, 4, outstanding-burst descriptor FIFO depth; power of two, ≥2.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `desc_push` in 1: DMA burst address fully issued; connect to `dma_xaddr_burst_ok`.
- `desc_split` in 1: burst was split at 4 KB; connect to `cross_4k_flag`.
- `desc_len` in 4: DMA burst length minus 1.
- `desc_first_len` in 4: first AXI sub-burst length minus 1; valid only when `desc_split`=1.
- `desc_full` out 1: descriptor FIFO full; the address side gates issue on it.
- `i_rvalid` in 1: AXI R valid.
- `i_rid` in AXI_IDW: AXI R ID.
- `i_rdata` in DATA_W: AXI R data.
- `i_rresp` in 2: AXI R response.
- `i_rlast` in 1: AXI R last.
- `o_rready` out 1: AXI R ready.
- `dma_rvalid` out 1: merged beat valid.
- `dma_rdata` out DATA_W: merged beat data.
- `dma_rresp` out 2: accumulated worst response.
- `dma_rlast` out 1: last beat of the DMA burst.
- `dma_rready` in 1: consumer ready.
- `axi_burst_xdata_ok` out 1: pulse when the merged last beat handshakes.
- `err_proto` out 1: pulse on an `i_rlast` position mismatch.
- `err_ovf` out 1: pulse on a push while the FIFO is full.

## Operation
- **Descriptor FIFO.** `desc_push` writes {split, len, first_len}. The head is popped when `axi_burst_xdata_ok` fires. Push and pop in the same cycle are allowed, including when full, because the pop frees the slot. A push when full and not popping is dropped and `err_ovf` pulses.
- **Data path.** Combinational pass-through gated by head valid:
  - `o_rready = dma_rready & head_valid`
  - `dma_rvalid = i_rvalid & head_valid`
  - `dma_rdata = i_rdata`
  - When the FIFO is empty, R beats are stalled, not dropped.
- **beat_cnt** (4 bits): increments on each beat handshake (`i_rvalid & o_rready`). It clears to 0 on the merged last beat.
- **dma_rlast** = (`beat_cnt == head.len`). The incoming `i_rlast` is never forwarded.
- **FSM `phase`:**
  - `PH_ONLY`: head not split.
  - `PH_FIRST`: split, first sub-burst.
  - `PH_SECOND`: split, second sub-burst.
  - On a new head, the FSM enters `PH_FIRST` if split, otherwise `PH_ONLY`.
  - `PH_FIRST` → `PH_SECOND` on the beat handshake where `beat_cnt == head.first_len`.
  - `PH_SECOND` or `PH_ONLY` → next head's phase on the merged-last handshake.
- **Protocol check.** `i_rlast` is expected on the handshake where `beat_cnt == first_len` (in `PH_FIRST`) or `beat_cnt == len` (otherwise). If `i_rlast` differs from the expected value on any handshake, `err_proto` pulses. Counting continues from the descriptor and is not resynchronised.
- **Response merge.** `resp_acc` is sticky worst-case, with order OKAY(0) < EXOKAY(1) < SLVERR(2) < DECERR(3).
  - `dma_rresp = max(resp_acc, i_rresp)`.
  - `resp_acc` clears on the merged last beat.

## Timing
- Data path latency: zero cycles, combinational from R to DMA and from `dma_rready` to `o_rready`.
- A descriptor pushed in cycle N governs beats from cycle N+1. A beat arriving in the same cycle as its push is stalled one cycle.
- `axi_burst_xdata_ok` is a single-cycle combinational pulse: `dma_rvalid & dma_rready & dma_rlast`.
- Reset values:
  - `o_rready`, `dma_rvalid`, `dma_rlast`, `axi_burst_xdata_ok`, `err_proto`, `err_ovf`, `desc_full` = 0; `dma_rresp` = 0.
  - FIFO empty; `beat_cnt` = 0; `phase` = `PH_ONLY`; `resp_acc` = 0.
- Reset mid-burst discards all descriptors and partial state; there is no recovery handshake.
- `desc_len`=0 (single beat) with `desc_split`=0 is legal: the first beat is last.
- `desc_split`=1 requires `desc_first_len < desc_len`. Otherwise the phase never advances and `err_proto` fires.

## Structure
- Shared package `idma_pkg`:
  - `rphase_e` {PH_ONLY, PH_FIRST, PH_SECOND}
  - `rdesc_t` {split, len[3:0], first_len[3:0]}
  - AXI response constants.
- Sub-module `idma_desc_fifo`: parameterised synchronous FIFO of `rdesc_t` with count, full and empty outputs.

## Test plan
- **Unsplit burst:** push len=7, split=0; feed 8 beats, `i_rlast` on beat 7 → 8 DMA beats, `dma_rlast` only on beat 7, one `axi_burst_xdata_ok`.
- **Split burst:** push len=15, first_len=5, split=1; feed 6 beats with rlast, then 10 beats with rlast → 16 DMA beats, the first `i_rlast` is suppressed, `dma_rlast` on beat 15, one `xdata_ok`.
- **Response merge:** split burst with SLVERR on beat 2 of the first half and OKAY elsewhere → `dma_rresp` = 2 from beat 2 through beat 15, and 0 on the following burst.
- **Backpressure and FIFO limits:**
  - Random `dma_rready` with 4 queued descriptors → data order preserved and `o_rready` mirrors `dma_rready`.
  - 5th push while full and not popping → `err_ovf` pulses; the push is dropped.
- **Protocol errors and stall:**
  - Unsplit len=3 with `i_rlast` on beat 2 → `err_proto` pulse on beat 2 and on beat 3; `dma_rlast` still on beat 3.
  - R beat with the FIFO empty → `o_rready` = 0 until the push.
- **Reset mid-burst:** deassert `aresetn` after beat 4 of 16 → all outputs return to 0 and `desc_full` = 0. A new len=0 burst then completes normally.

Source files
------------

// File: rtl/idma_pkg.sv
// idma_pkg: shared types and constants for the iDMA read-data path.
package idma_pkg;

    typedef enum logic [1:0] {
        PH_ONLY,
        PH_FIRST,
        PH_SECOND
    } rphase_e;

    typedef struct packed {
        logic       split;
        logic [3:0] len;
        logic [3:0] first_len;
    } rdesc_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    function automatic rphase_e entry_phase(input logic split);
        return split ? PH_FIRST : PH_ONLY;
    endfunction

endpackage

// File: rtl/idma_desc_fifo.sv
// idma_desc_fifo: synchronous descriptor FIFO exposing the head and the entry behind it.
module idma_desc_fifo
    import idma_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  rdesc_t      i_data,
    input  logic        i_pop,
    output rdesc_t      o_head,
    output rdesc_t      o_next,
    output logic [AW:0] o_count,
    output logic        o_full,
    output logic        o_empty
);

    rdesc_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_rd_nxt;
    logic          w_wr;
    logic          w_rd;

    assign o_count  = r_count;
    assign o_full   = r_count == (AW+1)'(DEPTH);
    assign o_empty  = r_count == '0;
    assign w_rd_nxt = r_rd + 1'b1;
    assign o_head   = r_mem[r_rd];
    assign o_next   = r_mem[w_rd_nxt];
    assign w_rd     = i_pop & ~o_empty;
    // A pop frees the head slot, so a push into a full FIFO is accepted then.
    assign w_wr     = i_push & (~o_full | w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= w_rd_nxt;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/axi_rdata_merge4k.sv
// axi_rdata_merge4k: merges the R beats of a 4 KB-split DMA burst into one burst
// with a single last, a worst-case response and a completion pulse.
module axi_rdata_merge4k
    import idma_pkg::*;
#(
    parameter int AXI_IDW    = 4,
    parameter int DATA_W     = 256,
    parameter int DESC_DEPTH = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               desc_push,
    input  logic               desc_split,
    input  logic [3:0]         desc_len,
    input  logic [3:0]         desc_first_len,
    output logic               desc_full,
    input  logic               i_rvalid,
    input  logic [AXI_IDW-1:0] i_rid,
    input  logic [DATA_W-1:0]  i_rdata,
    input  logic [1:0]         i_rresp,
    input  logic               i_rlast,
    output logic               o_rready,
    output logic               dma_rvalid,
    output logic [DATA_W-1:0]  dma_rdata,
    output logic [1:0]         dma_rresp,
    output logic               dma_rlast,
    input  logic               dma_rready,
    output logic               axi_burst_xdata_ok,
    output logic               err_proto,
    output logic               err_ovf
);

    localparam int CW = $clog2(DESC_DEPTH) + 1;

    rdesc_t        w_head;
    rdesc_t        w_next;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_hv;
    logic          w_hs;
    logic          w_exp_last;
    logic          w_unused;
    rphase_e       w_pop_ph;
    rphase_e       r_phase;
    logic [3:0]    r_beat_cnt;
    logic [1:0]    r_resp_acc;

    idma_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_push  (desc_push),
        .i_data  ('{split: desc_split, len: desc_len, first_len: desc_first_len}),
        .i_pop   (axi_burst_xdata_ok),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_unused           = ^{i_rid, w_head.split, w_next.len, w_next.first_len, w_count[0]};
    assign w_hv               = ~w_empty;
    assign desc_full          = w_full;
    assign o_rready           = dma_rready & w_hv;
    assign dma_rvalid         = i_rvalid & w_hv;
    assign dma_rdata          = i_rdata;
    assign dma_rlast          = w_hv & (r_beat_cnt == w_head.len);
    assign dma_rresp          = (i_rresp > r_resp_acc) ? i_rresp : r_resp_acc;
    assign w_hs               = i_rvalid & o_rready;
    assign axi_burst_xdata_ok = dma_rvalid & dma_rready & dma_rlast;
    assign err_ovf            = desc_push & w_full & ~axi_burst_xdata_ok;
    assign w_exp_last         = (r_phase == PH_FIRST) ? (r_beat_cnt == w_head.first_len) : dma_rlast;
    assign err_proto          = w_hs & (i_rlast != w_exp_last);
    // After a pop the new head is either the queued entry or the one being pushed now.
    assign w_pop_ph           = (|w_count[CW-1:1]) ? entry_phase(w_next.split) :
                                desc_push ? entry_phase(desc_split) : PH_ONLY;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_phase    <= PH_ONLY;
            r_beat_cnt <= '0;
            r_resp_acc <= RESP_OKAY;
        end else begin
            if (w_empty && desc_push)
                r_phase <= entry_phase(desc_split);
            else if (axi_burst_xdata_ok)
                r_phase <= w_pop_ph;
            else if (w_hs && r_phase == PH_FIRST && r_beat_cnt == w_head.first_len)
                r_phase <= PH_SECOND;
            if (w_hs) begin
                r_beat_cnt <= dma_rlast ? '0 : r_beat_cnt + 1'b1;
                r_resp_acc <= dma_rlast ? RESP_OKAY : dma_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axi_rdata_merge4k.sv
// tb_axi_rdata_merge4k: randomized bench with a queue-based reference model of the R-beat merger.
module tb_axi_rdata_merge4k;
    import idma_pkg::*;

    localparam int IDW   = 4;
    localparam int DW    = 256;
    localparam int DEPTH = 4;

    logic          aclk = 0;
    logic          aresetn = 1;
    logic          desc_push = 0;
    logic          desc_split = 0;
    logic [3:0]    desc_len = 0;
    logic [3:0]    desc_first_len = 0;
    logic          desc_full;
    logic          i_rvalid = 0;
    logic [IDW-1:0] i_rid = 0;
    logic [DW-1:0] i_rdata = '0;
    logic [1:0]    i_rresp = 0;
    logic          i_rlast = 0;
    logic          o_rready;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic [1:0]    dma_rresp;
    logic          dma_rlast;
    logic          dma_rready = 0;
    logic          axi_burst_xdata_ok;
    logic          err_proto;
    logic          err_ovf;

    int total = 0;
    int bad = 0;

    always #5 aclk = ~aclk;

    axi_rdata_merge4k #(.AXI_IDW(IDW), .DATA_W(DW), .DESC_DEPTH(DEPTH)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .desc_push          (desc_push),
        .desc_split         (desc_split),
        .desc_len           (desc_len),
        .desc_first_len     (desc_first_len),
        .desc_full          (desc_full),
        .i_rvalid           (i_rvalid),
        .i_rid              (i_rid),
        .i_rdata            (i_rdata),
        .i_rresp            (i_rresp),
        .i_rlast            (i_rlast),
        .o_rready           (o_rready),
        .dma_rvalid         (dma_rvalid),
        .dma_rdata          (dma_rdata),
        .dma_rresp          (dma_rresp),
        .dma_rlast          (dma_rlast),
        .dma_rready         (dma_rready),
        .axi_burst_xdata_ok (axi_burst_xdata_ok),
        .err_proto          (err_proto),
        .err_ovf            (err_ovf)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Reference model: queue of accepted descriptors, beat position inside the head burst,
    // and the worst response seen so far in that burst.
    typedef struct { bit split; int len; int fl; } md_t;
    md_t mq[$];
    int  pos = 0;
    int  acc = 0;
    int  n_xok = 0, n_last = 0, n_proto = 0, n_ovf = 0;
    int  resp_log[$];

    always @(negedge aclk) begin
        bit  hv, hs, lst, xok, explast;
        int  er;
        md_t h;
        if (!aresetn) begin
            mq.delete();
            pos = 0;
            acc = 0;
        end
        hv = mq.size() > 0;
        h = '{0, 0, 0};
        if (hv) h = mq[0];
        lst = hv && pos == h.len;
        hs = hv && i_rvalid && dma_rready;
        explast = (h.split && pos <= h.fl) ? (pos == h.fl) : lst;
        er = (int'(i_rresp) > acc) ? int'(i_rresp) : acc;
        xok = hs && lst;
        chk("o_rready", o_rready, dma_rready && hv);
        chk("dma_rvalid", dma_rvalid, i_rvalid && hv);
        chk("dma_rlast", dma_rlast, lst);
        chk("xdata_ok", axi_burst_xdata_ok, xok);
        chk("dma_rresp", dma_rresp, er);
        chk("err_proto", err_proto, hs && (i_rlast != explast));
        chk("err_ovf", err_ovf, desc_push && mq.size() == DEPTH && !xok);
        chk("desc_full", desc_full, mq.size() == DEPTH);
        if (i_rvalid && hv) chk("dma_rdata", dma_rdata, i_rdata);
        n_xok   += int'(axi_burst_xdata_ok);
        n_last  += int'(dma_rlast && dma_rvalid && dma_rready);
        n_proto += int'(err_proto);
        n_ovf   += int'(err_ovf);
        if (dma_rvalid && dma_rready) resp_log.push_back(int'(dma_rresp));
        if (aresetn) begin
            if (hs) begin
                acc = lst ? 0 : er;
                pos = lst ? 0 : pos + 1;
            end
            if (xok) void'(mq.pop_front());
            if (desc_push && mq.size() < DEPTH)
                mq.push_back('{desc_split, int'(desc_len), int'(desc_first_len)});
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input bit s, input int l, input int f);
        desc_push = 1;
        desc_split = s;
        desc_len = 4'(l);
        desc_first_len = 4'(f);
        step();
        desc_push = 0;
    endtask

    task automatic beat(input bit last, input logic [1:0] resp, input int pct);
        int n = 0;
        bit done = 0;
        i_rvalid = 1;
        i_rlast = last;
        i_rresp = resp;
        i_rid = 4'($urandom());
        for (int k = 0; k < DW / 32; k++) i_rdata[k*32 +: 32] = $urandom();
        while (!done) begin
            dma_rready = ($urandom_range(99) < pct);
            @(negedge aclk);
            done = o_rready;
            step();
            n++;
            if (!done && n > 50) begin
                total++;
                bad++;
                $display("FAIL beat_timeout: no handshake after %0d cycles, required one", n);
                done = 1;
            end
        end
        i_rvalid = 0;
        i_rlast = 0;
        i_rresp = 0;
        dma_rready = 0;
    endtask

    // rbeat < 0 selects a random response on every beat.
    task automatic burst(input bit s, input int l, input int f, input int pct,
                         input int rbeat, input logic [1:0] rval);
        for (int b = 0; b <= l; b++)
            beat(s ? (b == f || b == l) : (b == l),
                 (rbeat < 0) ? 2'($urandom()) : ((b == rbeat) ? rval : 2'd0), pct);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int x0, l0, p0, o0;
        bit ss[4];
        int ll[4], ff[4];
        #1 aresetn = 0;
        dma_rready = 1;
        i_rvalid = 1;
        repeat (2) @(negedge aclk);
        chk("rst_o_rready", o_rready, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_dma_rlast", dma_rlast, 0);
        chk("rst_desc_full", desc_full, 0);
        chk("rst_xdata_ok", axi_burst_xdata_ok, 0);
        chk("rst_dma_rresp", dma_rresp, 0);
        step();
        aresetn = 1;
        i_rvalid = 0;
        dma_rready = 0;
        step();

        x0 = n_xok; l0 = n_last;
        push(0, 7, 0);
        burst(0, 7, 0, 100, 99, 0);
        chk("unsplit_xok_count", n_xok - x0, 1);
        chk("unsplit_last_count", n_last - l0, 1);

        x0 = n_xok; l0 = n_last; p0 = n_proto;
        push(1, 15, 5);
        burst(1, 15, 5, 100, 99, 0);
        chk("split_xok_count", n_xok - x0, 1);
        chk("split_last_count", n_last - l0, 1);
        chk("split_proto_count", n_proto - p0, 0);

        resp_log.delete();
        push(1, 15, 5);
        burst(1, 15, 5, 100, 2, RESP_SLVERR);
        chk("resp_beats", resp_log.size(), 16);
        if (resp_log.size() == 16) begin
            chk("resp_beat1", resp_log[1], 0);
            chk("resp_beat2", resp_log[2], 2);
            chk("resp_beat6", resp_log[6], 2);
            chk("resp_beat15", resp_log[15], 2);
        end
        resp_log.delete();
        push(0, 0, 0);
        burst(0, 0, 0, 100, 99, 0);
        chk("resp_next_burst", resp_log.size() == 1 ? resp_log[0] : -1, 0);

        for (int i = 0; i < 4; i++) begin
            ss[i] = 1'($urandom());
            ll[i] = $urandom_range(15, 1);
            ff[i] = ss[i] ? $urandom_range(ll[i] - 1, 0) : 0;
            push(ss[i], ll[i], ff[i]);
        end
        @(negedge aclk);
        chk("fifo_full", desc_full, 1);
        step();
        o0 = n_ovf;
        push(0, 3, 0);
        chk("ovf_pulse_count", n_ovf - o0, 1);
        x0 = n_xok;
        for (int i = 0; i < 4; i++) burst(ss[i], ll[i], ff[i], 50, -1, 0);
        chk("bp_xok_count", n_xok - x0, 4);
        dma_rready = 1;
        @(negedge aclk);
        chk("ovf_dropped_empty", o_rready, 0);
        step();
        dma_rready = 0;

        p0 = n_proto; l0 = n_last;
        push(0, 3, 0);
        beat(0, 0, 100);
        beat(0, 0, 100);
        beat(1, 0, 100);
        beat(0, 0, 100);
        chk("proto_err_count", n_proto - p0, 2);
        chk("proto_last_count", n_last - l0, 1);

        i_rvalid = 1;
        dma_rready = 1;
        i_rlast = 0;
        i_rdata = {8{32'hA5A5_0001}};
        repeat (3) begin
            @(negedge aclk);
            chk("stall_empty", o_rready, 0);
            step();
        end
        desc_push = 1;
        desc_split = 0;
        desc_len = 4'd1;
        desc_first_len = 4'd0;
        @(negedge aclk);
        chk("stall_push_cycle", o_rready, 0);
        step();
        desc_push = 0;
        @(negedge aclk);
        chk("stall_after_push", o_rready, 1);
        step();
        beat(1, 0, 100);

        push(0, 15, 0);
        for (int b = 0; b < 4; b++) beat(0, 0, 100);
        i_rvalid = 1;
        dma_rready = 1;
        #1 aresetn = 0;
        #1;
        chk("midrst_o_rready", o_rready, 0);
        chk("midrst_dma_rvalid", dma_rvalid, 0);
        chk("midrst_dma_rlast", dma_rlast, 0);
        chk("midrst_desc_full", desc_full, 0);
        chk("midrst_xdata_ok", axi_burst_xdata_ok, 0);
        step();
        step();
        aresetn = 1;
        i_rvalid = 0;
        dma_rready = 0;
        step();
        x0 = n_xok;
        push(0, 0, 0);
        burst(0, 0, 0, 100, 99, 0);
        chk("postrst_xok_count", n_xok - x0, 1);

        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(3, 1);
            for (int i = 0; i < k; i++) begin
                ss[i] = 1'($urandom());
                ll[i] = ss[i] ? $urandom_range(15, 1) : $urandom_range(15, 0);
                ff[i] = ss[i] ? $urandom_range(ll[i] - 1, 0) : 0;
                push(ss[i], ll[i], ff[i]);
            end
            for (int i = 0; i < k; i++) burst(ss[i], ll[i], ff[i], $urandom_range(100, 30), -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
